// File: rtl/spart.sv
`default_nettype none
// =============================================================================
// spart : bus-mapped UART, 8N1 framing, 16x oversampled baud enable
// Rev 1.0
// =============================================================================
module spart #(
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [15:0] r_db;
    logic [15:0] r_baud;
    logic [15:0] w_db_nxt;
    logic        w_en;
    logic        w_rd;
    logic        w_wr;
    logic        w_wr_tx;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_rd_buf;
    logic [7:0]  w_rdata;

    state_t      r_tx_state;
    state_t      w_tx_state_nxt;
    logic [3:0]  r_tx_tick;
    logic [3:0]  w_tx_tick_nxt;
    logic [2:0]  r_tx_bit;
    logic [2:0]  w_tx_bit_nxt;
    logic [7:0]  r_tx_shift;
    logic [7:0]  w_tx_shift_nxt;
    logic        r_tbr;
    logic        w_tx_done;
    logic        w_txd;

    logic [1:0]  r_sync;
    logic        w_rxs;
    state_t      r_rx_state;
    state_t      w_rx_state_nxt;
    logic [3:0]  r_rx_tick;
    logic [3:0]  w_rx_tick_nxt;
    logic [2:0]  r_rx_bit;
    logic [2:0]  w_rx_bit_nxt;
    logic [7:0]  r_rx_shift;
    logic [7:0]  w_rx_shift_nxt;
    logic [7:0]  r_rx_buf;
    logic        r_rda;
    logic        w_rx_load;

    assign w_rd     = iocs & iorw;
    assign w_wr     = iocs & ~iorw;
    assign w_wr_tx  = w_wr & (ioaddr == 2'b00) & r_tbr;
    assign w_wr_lo  = w_wr & (ioaddr == 2'b10);
    assign w_wr_hi  = w_wr & (ioaddr == 2'b11);
    assign w_rd_buf = w_rd & (ioaddr == 2'b00);
    assign w_db_nxt = {w_wr_hi ? databus : r_db[15:8], w_wr_lo ? databus : r_db[7:0]};
    assign w_en     = (r_baud == 16'd0);
    assign w_rxs    = r_sync[1];

    always_comb begin
        w_rdata = r_rx_buf;
        case (ioaddr)
            2'b01:   w_rdata = {6'b0, r_tbr, r_rda};
            2'b10:   w_rdata = r_db[7:0];
            2'b11:   w_rdata = r_db[15:8];
            default: w_rdata = r_rx_buf;
        endcase
    end

    assign databus = w_rd ? w_rdata : 8'hzz;
    assign rda     = r_rda;
    assign tbr     = r_tbr;
    assign txd     = w_txd;

    // A divisor write restarts the count so the new rate applies immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db   <= DIV_RESET;
            r_baud <= DIV_RESET;
        end else begin
            r_db <= w_db_nxt;
            if (w_wr_lo || w_wr_hi)
                r_baud <= w_db_nxt;
            else if (w_en)
                r_baud <= r_db;
            else
                r_baud <= r_baud - 16'd1;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_tick_nxt  = r_tx_tick;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_done      = 1'b0;
        w_txd          = 1'b1;
        case (r_tx_state)
            ST_IDLE: begin
                if (!r_tbr && w_en) begin
                    w_tx_state_nxt = ST_START;
                    w_tx_tick_nxt  = 4'd0;
                end
            end
            ST_START: begin
                w_txd = 1'b0;
                if (w_en) begin
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) begin
                        w_tx_state_nxt = ST_DATA;
                        w_tx_bit_nxt   = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                w_txd = r_tx_shift[0];
                if (w_en) begin
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) begin
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        if (r_tx_bit == 3'd7)
                            w_tx_state_nxt = ST_STOP;
                        else
                            w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_en) begin
                    w_tx_tick_nxt = r_tx_tick + 4'd1;
                    if (r_tx_tick == 4'd15) begin
                        w_tx_state_nxt = ST_IDLE;
                        w_tx_done      = 1'b1;
                    end
                end
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_tick  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tbr      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_tick  <= w_tx_tick_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_wr_tx ? databus : w_tx_shift_nxt;
            if (w_wr_tx)
                r_tbr <= 1'b0;
            else if (w_tx_done)
                r_tbr <= 1'b1;
        end
    end

    // Start is re-checked at mid-bit so short line glitches are rejected.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_tick_nxt  = r_rx_tick;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_load      = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (w_en && !w_rxs) begin
                    w_rx_state_nxt = ST_START;
                    w_rx_tick_nxt  = 4'd0;
                end
            end
            ST_START: begin
                if (w_en) begin
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd7) begin
                        w_rx_tick_nxt = 4'd0;
                        w_rx_bit_nxt  = 3'd0;
                        w_rx_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_en) begin
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        w_rx_shift_nxt = {w_rxs, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7)
                            w_rx_state_nxt = ST_STOP;
                        else
                            w_rx_bit_nxt = r_rx_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_en) begin
                    w_rx_tick_nxt = r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        w_rx_state_nxt = ST_IDLE;
                        w_rx_load      = w_rxs;
                    end
                end
            end
            default: w_rx_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync     <= 2'b11;
            r_rx_state <= ST_IDLE;
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
            r_rx_buf   <= 8'd0;
            r_rda      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rx_state <= w_rx_state_nxt;
            r_rx_tick  <= w_rx_tick_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            if (w_rx_load)
                r_rx_buf <= r_rx_shift;
            if (w_rx_load)
                r_rda <= 1'b1;
            else if (w_rd_buf)
                r_rda <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spart.sv
`default_nettype none
// =============================================================================
// tb_spart : self-checking bench for spart (frame-level transmit model + directed bus/serial vectors)
// Rev 1.0
// =============================================================================
module tb_spart;

    localparam logic [15:0] C_DIV = 16'd325;

    logic       clk = 1'b0;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd_w;
    logic       tb_drv;
    logic [7:0] tb_dout;
    logic       rx_tb;
    logic       loop;

    int n_tests = 0;
    int n_fail  = 0;

    assign databus = tb_drv ? tb_dout : 8'hzz;
    assign rxd_w   = loop ? txd : rx_tb;

    always #5 clk = ~clk;

    spart #(.DIV_RESET(C_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .iocs   (iocs),
        .iorw   (iorw),
        .ioaddr (ioaddr),
        .databus(databus),
        .rda    (rda),
        .tbr    (tbr),
        .txd    (txd),
        .rxd    (rxd_w)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmit model: en pulses derived from edge count since the last divisor load,
    // and the frame described as 160 en-periods of 10 bit slots.
    int          m_cyc;
    int          m_load;
    logic [15:0] m_db;
    logic        m_tbr;
    logic        m_act;
    int          m_n;
    logic [7:0]  m_byte;

    always @(posedge clk or posedge rst) begin : model
        logic en;
        if (rst) begin
            m_cyc  <= 0;
            m_load <= 0;
            m_db   <= C_DIV;
            m_tbr  <= 1'b1;
            m_act  <= 1'b0;
            m_n    <= 0;
            m_byte <= 8'd0;
        end else begin
            en = ((m_cyc - m_load) % (int'(m_db) + 1)) == int'(m_db);
            m_cyc <= m_cyc + 1;
            if (m_act) begin
                if (en) begin
                    if (m_n == 159) begin
                        m_act <= 1'b0;
                        m_tbr <= 1'b1;
                    end else begin
                        m_n <= m_n + 1;
                    end
                end
            end else if (!m_tbr && en) begin
                m_act <= 1'b1;
                m_n   <= 0;
            end
            if (iocs && !iorw && ioaddr == 2'b00 && m_tbr) begin
                m_tbr  <= 1'b0;
                m_byte <= tb_dout;
            end
            if (iocs && !iorw && ioaddr[1]) begin
                m_load <= m_cyc + 1;
                if (ioaddr[0]) m_db[15:8] <= tb_dout;
                else           m_db[7:0]  <= tb_dout;
            end
        end
    end

    function automatic logic exp_txd();
        int b;
        if (!m_act) return 1'b1;
        b = m_n / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_txd", {15'd0, txd}, {15'd0, exp_txd()});
            chk("model_tbr", {15'd0, tbr}, {15'd0, m_tbr});
        end
    end

    task automatic bus_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a; tb_drv = 1'b0;
        #1 chk(nm, {8'd0, databus}, {8'd0, exp});
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_drv = 1'b1; tb_dout = d;
        @(negedge clk);
        iocs = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic wait_sig(input string nm, input int budget, input bit which);
        int k;
        k = 0;
        while (k < budget && ((which == 1'b0) ? tbr !== 1'b1 : rda !== 1'b1)) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {15'd0, (which == 1'b0) ? tbr : rda}, 16'd1);
    endtask

    // Drives one serial frame on rxd (64 clks per bit at DB=3), started on a fixed en phase.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int read_at,
                              input logic [7:0] exp_old, input int tx_at, output int rise_at);
        int bi;
        rise_at = -1;
        while (((m_cyc - m_load) % (int'(m_db) + 1)) != 0) @(negedge clk);
        for (int k = 0; k < 720; k++) begin
            if (rda && rise_at < 0) rise_at = k;
            if (read_at >= 0 && k == read_at + 1) begin
                chk("collision_rda", {15'd0, rda}, 16'd1);
                iocs = 1'b0;
            end
            if (tx_at >= 0 && k == tx_at + 1) begin
                iocs = 1'b0; tb_drv = 1'b0;
            end
            if (k == read_at) begin
                iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; tb_drv = 1'b0;
                #1 chk("collision_old", {8'd0, databus}, {8'd0, exp_old});
            end
            if (k == tx_at) begin
                iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tb_drv = 1'b1; tb_dout = 8'h5A;
            end
            bi = k / 64;
            if (bi == 0)      rx_tb = 1'b0;
            else if (bi <= 8) rx_tb = b[bi-1];
            else if (bi == 9) rx_tb = stop_ok ? 1'b1 : ((k % 64) >= 48);
            else              rx_tb = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        int lo;
        int r1, r2, r3, r4;
        logic [7:0] tx_byte;
        rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        tb_drv = 1'b0; tb_dout = 8'h00; rx_tb = 1'b1; loop = 1'b0;
        repeat (3) @(negedge clk);
        tb_drv = 1'b1; tb_dout = 8'h3C;
        #1 chk("bus_z_reset", {8'd0, databus}, 16'h003C);
        tb_drv = 1'b0;
        chk("txd_reset", {15'd0, txd}, 16'd1);
        chk("tbr_reset", {15'd0, tbr}, 16'd1);
        chk("rda_reset", {15'd0, rda}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        bus_read(2'b01, 8'h02, "status_reset");
        bus_read(2'b10, 8'h45, "db_lo_reset");
        bus_read(2'b11, 8'h01, "db_hi_reset");
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        bus_read(2'b10, 8'h03, "db_lo_new");
        bus_read(2'b11, 8'h00, "db_hi_new");

        // Transmit 0x55 and pin the waveform with literal timings.
        tx_byte = 8'h55;
        bus_write(2'b00, tx_byte);
        chk("tbr_clear", {15'd0, tbr}, 16'd0);
        lo = 0;
        while (lo < 200 && txd === 1'b1) begin @(negedge clk); lo++; end
        chk("tx_start_seen", {15'd0, txd}, 16'd0);
        lo = 0;
        while (lo < 200 && txd === 1'b0) begin @(negedge clk); lo++; end
        chk("start_len", 16'(lo), 16'd64);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 64; k++) begin
                if (k == 32) chk("tx_bit", {15'd0, txd}, {15'd0, tx_byte[i]});
                if (i == 2 && k == 10) begin
                    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00; tb_drv = 1'b1; tb_dout = 8'hFF;
                end
                if (i == 2 && k == 11) begin
                    iocs = 1'b0; tb_drv = 1'b0;
                end
                @(negedge clk);
            end
        end
        repeat (32) @(negedge clk);
        chk("tx_stop", {15'd0, txd}, 16'd1);
        wait_sig("tbr_set", 100, 1'b0);

        // Loopback.
        loop = 1'b1;
        bus_write(2'b00, 8'hA5);
        wait_sig("loop_rda", 2000, 1'b1);
        bus_read(2'b00, 8'hA5, "loop_data");
        chk("rda_clear", {15'd0, rda}, 16'd0);
        wait_sig("loop_tbr", 200, 1'b0);
        bus_read(2'b01, 8'h02, "status_after");
        loop = 1'b0;

        // False start glitch: 8 clks low = 2 en periods.
        rx_tb = 1'b0;
        repeat (8) @(negedge clk);
        rx_tb = 1'b1;
        repeat (800) @(negedge clk);
        chk("false_start", {15'd0, rda}, 16'd0);

        send_frame(8'h3C, 1'b0, -1, 8'h00, -1, r1);
        chk("framing_err", {15'd0, rda}, 16'd0);
        bus_read(2'b00, 8'hA5, "buf_kept");

        // Overrun, then read colliding with completion.
        send_frame(8'h11, 1'b1, -1, 8'h00, -1, r1);
        chk("rx11_rda", {15'd0, rda}, 16'd1);
        chk("rx_latency", {15'd0, (r1 >= 600 && r1 <= 660)}, 16'd1);
        send_frame(8'h22, 1'b1, -1, 8'h00, -1, r2);
        chk("overrun_rda", {15'd0, rda}, 16'd1);
        bus_read(2'b00, 8'h22, "overrun_data");
        send_frame(8'h33, 1'b1, r1 - 1, 8'h22, -1, r3);
        bus_read(2'b00, 8'h33, "third_data");

        // Concurrent receive with transmit, then reset mid-transmit.
        send_frame(8'h44, 1'b1, -1, 8'h00, 100, r4);
        chk("rx44_rda", {15'd0, rda}, 16'd1);
        wait_sig("tbr_5a_done", 200, 1'b0);
        bus_write(2'b00, 8'hC3);
        repeat (200) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_tbr", {15'd0, tbr}, 16'd1);
        chk("rst_rda", {15'd0, rda}, 16'd0);
        tb_drv = 1'b1; tb_dout = 8'h96;
        #1 chk("rst_bus_z", {8'd0, databus}, 16'h0096);
        tb_drv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(2'b10, 8'h45, "db_lo_rst");
        bus_read(2'b11, 8'h01, "db_hi_rst");
        bus_read(2'b01, 8'h02, "status_rst");
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spart.md
Name: spart

Overview:
- Peripheral-side responder for the processor I/O bus: a Special Purpose Asynchronous Receiver/Transmitter.
- Decodes iocs/iorw/ioaddr from the bus driver, holds the 16-bit baud divisor, serializes transmit bytes on txd and deserializes rxd.
- Reports tbr/rda status, and returns read data on the shared tri-state databus.
- 8N1 framing, 16x oversampling.

Parameters:
- DIV_RESET, 16'd325, divisor loaded at reset (9600 baud at 50 MHz with 16x oversampling).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- iocs  input  1  chip select; a bus transaction occurs on every clk edge where iocs=1.
- iorw  input  1  1=read (spart drives databus), 0=write (spart samples databus).
- ioaddr  input  2  register select: 00 TX/RX buffer, 01 status, 10 DB low, 11 DB high.
- databus  inout  8  shared data bus.
- rda  output  1  receive data available.
- tbr  output  1  transmit buffer ready.
- txd  output  1  serial out, idle high.
- rxd  input  1  serial in, asynchronous to clk.

Behaviour:
- Reset: txd=1, tbr=1, rda=0, databus=Z, DB=DIV_RESET, baud counter=DIV_RESET, TX/RX FSMs IDLE, RX synchronizer flops=1, rx buffer=0.
- Bus read path (iocs=1, iorw=1):
  - databus driven combinationally: 00 -> rx buffer; 01 -> {6'b0, tbr, rda}; 10 -> DB[7:0]; 11 -> DB[15:8].
  - databus is Z at all other times.
- Bus write path (iocs=1, iorw=0, registered at posedge):
  - 00: load TX shift register and clear tbr, only if tbr=1; ignored if tbr=0.
  - 10/11: write DB low/high byte and reload the baud counter with the new DB value in the same edge.
  - 01: ignored.
- Read of 00 clears rda at that edge.
- Read of 00 coinciding with RX completing a byte: the new byte is loaded and rda stays 1 (set wins).
- Baud generator:
  - 16-bit down counter; at 0 it emits en for one cycle and reloads DB.
  - en period = DB+1 clk cycles; DB=0 gives en every cycle.
  - One bit time = 16 en pulses.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: txd=1. On tbr=0, move to START at the next en; 4-bit tick counter cleared.
  - START: txd=0 for 16 en.
  - DATA: 8 bits LSB first, 16 en each; 3-bit bit counter.
  - STOP: txd=1 for 16 en, then tbr=1 and return to IDLE.
  - Back-to-back: a write on the cycle tbr returns to 1 is accepted.
- RX FSM, states IDLE -> START -> DATA -> STOP, with rxd passed through a 2-flop synchronizer:
  - IDLE: on en with synced rxd=0, go to START and clear the tick counter.
  - START: after 8 en (mid-bit), if rxd=0 go to DATA; else false start, return to IDLE.
  - DATA: sample every 16 en, shift in LSB first, 8 bits.
  - STOP: after 16 en, sample. If 1: load rx buffer, rda=1, IDLE. If 0: framing error, byte discarded, rda unchanged, IDLE.
  - Overrun: a new byte overwrites the rx buffer; rda stays 1.
- Reset asserted mid-frame: immediately txd=1, tbr=1, rda=0, both FSMs IDLE, partial data lost.
- TX and RX operate independently and concurrently off the shared en.

Test Plan:
- Divisor/status: after reset read 01 -> 8'h02 and read 10/11 -> 8'h45/8'h01. Write 10=8'h03, 11=8'h00, then read back -> 03/00, and en occurs every 4 clks.
- TX frame, DB=3: write 00=8'h55 -> tbr=0 next cycle; txd shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each 64 clks; tbr=1 after stop. A write to 00 while tbr=0 is ignored (frame unchanged).
- Loopback, txd tied to rxd: send 8'hA5 -> rda=1 after stop mid-sample; read 00 -> 8'hA5, rda=0 next cycle; status 01 -> 8'h02.
- False start / framing: 2-en-wide low glitch on rxd -> no rda. Frame with stop bit=0 -> rda stays 0.
- Overrun and read/set collision: receive 8'h11 then 8'h22 without reading -> read 00 gives 8'h22, rda=1. Read 00 on the completion cycle of a third byte -> rda remains 1.
- Reset mid-transmit: assert rst halfway through DATA -> txd=1, tbr=1, rda=0 immediately; DB=16'd325 and databus=Z.
